mips_multicycle_ctrl: RTL and testbench

Multicycle sequencer for the MIPS core. It replaces the single-cycle main/ALU decoders with a state machine that drives a shared-memory datapath. That datapath contains PC, IR, MDR, A/B and ALUOut registers, and uses one memory port for both instructions and data. The sequencer supports the same instruction set as the single-cycle core and adds a memory wait-state handshake.

---
 rtl/mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer driving a shared-memory datapath (PC, IR, MDR, A/B, ALUOut).
// State is registered; datapath controls are decoded from the current state, plus mem_ready/zero qualifiers.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               memreq,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcen,
    output logic [1:0]         pcsrc,
    output logic               regwrite,
    output logic [1:0]         regdst,
    output logic [1:0]         memtoreg,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic               signext,
    output logic               shiftl16,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b000000, 6'b100000, 6'b100001, 6'b100010,
            6'b100011, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                                    funct_legal = 1'b0;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:                         state_q <= funct_legal(funct) ? S_EXEC : S_HALT;
                        OP_LW, OP_SW:                     state_q <= S_MEMADR;
                        OP_BEQ:                           state_q <= S_BRANCH;
                        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_q <= S_IEXEC;
                        OP_J:                             state_q <= S_JUMP;
                        OP_JAL:                           state_q <= S_JAL;
                        default:                          state_q <= S_HALT;
                    endcase
                end
                S_MEMADR: state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_IEXEC:  state_q <= S_IWB;
                S_HALT:   state_q <= S_HALT;
                // MEMWB, ALUWB, BRANCH, IWB, JUMP, JAL all complete in one cycle
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        memreq     = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        regwrite   = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        signext    = 1'b0;
        shiftl16   = 1'b0;
        alucontrol = ALU_AND;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                memreq     = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pcen       = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                signext    = 1'b1;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                signext    = 1'b1;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
            end
            S_MEMWR: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 2'b01;
                casez (funct)
                    6'b000000: alucontrol = ALU_OR;
                    6'b10000?: alucontrol = ALU_ADD;
                    6'b10001?: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
            end
            S_BRANCH: begin
                alusrca    = 2'b01;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            S_IEXEC: begin
                alusrcb = 2'b10;
                case (op)
                    OP_ORI: begin
                        alusrca    = 2'b01;
                        alucontrol = ALU_OR;
                    end
                    OP_LUI: begin
                        alusrca    = 2'b10;
                        shiftl16   = 1'b1;
                        alucontrol = ALU_ADD;
                    end
                    default: begin
                        alusrca    = 2'b01;
                        signext    = 1'b1;
                        alucontrol = ALU_ADD;
                    end
                endcase
            end
            S_IWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            // PC already holds PC+4, so $31 gets the return address on the same edge the PC jumps
            S_JAL: begin
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
                pcsrc    = 2'b10;
                pcen     = 1'b1;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase

        // Reset blocks every side-effecting strobe at once, independent of the clock.
        if (!reset) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks instruction sequences and checks states and controls.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       memreq, memwrite, iord, irwrite, pcen, regwrite, signext, shiftl16, illegal;
    logic [1:0] pcsrc, regdst, memtoreg, alusrca, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .memreq     (memreq),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .signext    (signext),
        .shiftl16   (shiftl16),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, where outputs of the current state are stable.
    task automatic step_state(input string tag, input logic [3:0] exp);
        @(negedge clk);
        check(tag, 32'(state), 32'(exp));
    endtask

    initial begin
        reset     = 1'b0;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Held in reset: FETCH state, strobes forced low even with mem_ready high
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_memreq", 32'(memreq), 32'd0);
        check("rst_irwrite", 32'(irwrite), 32'd0);
        check("rst_pcen", 32'(pcen), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // add $1,$2,$3 (0x00430820): 0,1,6,7,0
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("add_f_memreq", 32'(memreq), 32'd1);
        check("add_f_irwrite", 32'(irwrite), 32'd1);
        check("add_f_pcen", 32'(pcen), 32'd1);
        check("add_f_iord", 32'(iord), 32'd0);
        check("add_f_alusrcb", 32'(alusrcb), 32'd1);
        check("add_f_aluctl", 32'(alucontrol), 32'b010);
        step_state("add_s1", 4'd1);
        check("add_d_alusrcb", 32'(alusrcb), 32'd3);
        check("add_d_signext", 32'(signext), 32'd1);
        check("add_d_memreq", 32'(memreq), 32'd0);
        step_state("add_s6", 4'd6);
        check("add_e_aluctl", 32'(alucontrol), 32'b010);
        check("add_e_alusrca", 32'(alusrca), 32'd1);
        check("add_e_alusrcb", 32'(alusrcb), 32'd0);
        check("add_e_regwrite", 32'(regwrite), 32'd0);
        step_state("add_s7", 4'd7);
        check("add_wb_regwrite", 32'(regwrite), 32'd1);
        check("add_wb_regdst", 32'(regdst), 32'd1);
        check("add_wb_memtoreg", 32'(memtoreg), 32'd0);
        step_state("add_s0", 4'd0);

        // sub in EXEC, then reset asserted mid-EXEC
        funct = 6'b100010;
        step_state("sub_s1", 4'd1);
        step_state("sub_s6", 4'd6);
        check("sub_aluctl", 32'(alucontrol), 32'b110);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_regwrite", 32'(regwrite), 32'd0);
        check("midrst_memreq", 32'(memreq), 32'd0);
        step_state("midrst_hold", 4'd0);
        check("midrst_hold_regwrite", 32'(regwrite), 32'd0);
        op    = 6'b100011;
        funct = 6'b000100;
        reset = 1'b1;
        #1;
        check("rel_memreq", 32'(memreq), 32'd1);

        // lw 0x8C220004 with two wait cycles: 0,1,2,3,3,3,4,0
        step_state("lw_s1", 4'd1);
        step_state("lw_s2", 4'd2);
        check("lw_adr_alusrca", 32'(alusrca), 32'd1);
        check("lw_adr_alusrcb", 32'(alusrcb), 32'd2);
        check("lw_adr_signext", 32'(signext), 32'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_state($sformatf("lw_rd%0d_state", i), 4'd3);
            check($sformatf("lw_rd%0d_memreq", i), 32'(memreq), 32'd1);
            check($sformatf("lw_rd%0d_iord", i), 32'(iord), 32'd1);
            check($sformatf("lw_rd%0d_irwrite", i), 32'(irwrite), 32'd0);
            if (i == 2) mem_ready = 1'b1;
        end
        step_state("lw_s4", 4'd4);
        check("lw_wb_regwrite", 32'(regwrite), 32'd1);
        check("lw_wb_memtoreg", 32'(memtoreg), 32'd1);
        check("lw_wb_regdst", 32'(regdst), 32'd0);
        check("lw_wb_memreq", 32'(memreq), 32'd0);
        step_state("lw_s0", 4'd0);

        // beq taken, then not taken: 3 cycles each
        op   = 6'b000100;
        zero = 1'b1;
        step_state("beq1_s1", 4'd1);
        step_state("beq1_s8", 4'd8);
        check("beq1_pcen", 32'(pcen), 32'd1);
        check("beq1_pcsrc", 32'(pcsrc), 32'd1);
        check("beq1_aluctl", 32'(alucontrol), 32'b110);
        check("beq1_regwrite", 32'(regwrite), 32'd0);
        zero = 1'b0;
        step_state("beq1_s0", 4'd0);
        step_state("beq0_s1", 4'd1);
        step_state("beq0_s8", 4'd8);
        check("beq0_pcen", 32'(pcen), 32'd0);
        check("beq0_pcsrc", 32'(pcsrc), 32'd1);
        step_state("beq0_s0", 4'd0);

        // fetch wait state
        mem_ready = 1'b0;
        #1;
        check("fwait_irwrite", 32'(irwrite), 32'd0);
        check("fwait_pcen", 32'(pcen), 32'd0);
        check("fwait_memreq", 32'(memreq), 32'd1);
        step_state("fwait_hold", 4'd0);
        mem_ready = 1'b1;

        // jal 0x0C000010
        op = 6'b000011;
        step_state("jal_s1", 4'd1);
        step_state("jal_s12", 4'd12);
        check("jal_regwrite", 32'(regwrite), 32'd1);
        check("jal_regdst", 32'(regdst), 32'd2);
        check("jal_memtoreg", 32'(memtoreg), 32'd2);
        check("jal_pcen", 32'(pcen), 32'd1);
        check("jal_pcsrc", 32'(pcsrc), 32'd2);
        step_state("jal_s0", 4'd0);

        // lui 0x3C011234
        op = 6'b001111;
        step_state("lui_s1", 4'd1);
        step_state("lui_s9", 4'd9);
        check("lui_alusrca", 32'(alusrca), 32'd2);
        check("lui_alusrcb", 32'(alusrcb), 32'd2);
        check("lui_shiftl16", 32'(shiftl16), 32'd1);
        check("lui_signext", 32'(signext), 32'd0);
        check("lui_aluctl", 32'(alucontrol), 32'b010);
        step_state("lui_s10", 4'd10);
        check("lui_wb_regwrite", 32'(regwrite), 32'd1);
        check("lui_wb_regdst", 32'(regdst), 32'd0);
        step_state("lui_s0", 4'd0);

        // ori: zero-extended immediate, OR
        op = 6'b001101;
        step_state("ori_s1", 4'd1);
        step_state("ori_s9", 4'd9);
        check("ori_aluctl", 32'(alucontrol), 32'b001);
        check("ori_signext", 32'(signext), 32'd0);
        check("ori_alusrca", 32'(alusrca), 32'd1);
        step_state("ori_s10", 4'd10);
        step_state("ori_s0", 4'd0);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        step_state("sw_s1", 4'd1);
        step_state("sw_s2", 4'd2);
        step_state("sw_s5", 4'd5);
        check("sw_memwrite", 32'(memwrite), 32'd1);
        check("sw_memreq", 32'(memreq), 32'd1);
        check("sw_iord", 32'(iord), 32'd1);
        check("sw_regwrite", 32'(regwrite), 32'd0);
        step_state("sw_s0", 4'd0);

        // illegal op 0x3F: HALT for 10 cycles, then reset
        op = 6'b111111;
        step_state("ill_s1", 4'd1);
        for (int i = 0; i < 10; i++) begin
            step_state($sformatf("ill%0d_state", i), 4'd13);
            check($sformatf("ill%0d_illegal", i), 32'(illegal), 32'd1);
            check($sformatf("ill%0d_memreq", i), 32'(memreq), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("ill_rst_state", 32'(state), 32'd0);
        check("ill_rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // illegal R-type funct also halts
        op    = 6'b000000;
        funct = 6'b001000;
        step_state("badfn_s1", 4'd1);
        step_state("badfn_s13", 4'd13);
        check("badfn_illegal", 32'(illegal), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
